// File: rtl/cpuy_pkg.sv
// Shared CPU types for the ALU writeback slice.
//   wb_state_t     : writeback FSM state (IDLE, WR_L, WR_H)
//   REG_ADDR_W_DEF : default register-file address width
//   flags_t        : architectural carry/zero/sign flags
package cpuy_pkg;

  localparam int REG_ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_L = 2'd1,
    WR_H = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic sign;
  } flags_t;

endpackage

// File: rtl/alu_writeback_if.sv
// ALU -> writeback result channel.
//   Handshake: a result transfers on a rising clk edge where in_valid and
//   in_ready are both 1. The producer holds in_valid and all payload
//   (wide, dst, update_flags, result_l, result_h, carry, zero, sign)
//   stable until that edge; the consumer may drop in_ready at any time.
//   master : ALU side (drives valid + payload, observes in_ready)
//   slave  : writeback side (observes valid + payload, drives in_ready)
interface alu_writeback_if
  import cpuy_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  wide;
  logic [REG_ADDR_W-1:0] dst;
  logic                  update_flags;
  logic [7:0]            result_l;
  logic [7:0]            result_h;
  logic                  carry;
  logic                  zero;
  logic                  sign;

  modport master (
    output in_valid, wide, dst, update_flags, result_l, result_h,
           carry, zero, sign,
    input  in_ready
  );

  modport slave (
    input  in_valid, wide, dst, update_flags, result_l, result_h,
           carry, zero, sign,
    output in_ready
  );

endinterface

// File: rtl/alu_flags_reg.sv
// Architectural flag register with load enable.
//   clk, rst      : clock, asynchronous active-low reset (clears flags)
//   load          : capture d on the rising edge
//   d             : incoming carry/zero/sign
//   cpu_carry     : stored carry, fed back to the ALU
//   flag_zero     : stored zero
//   flag_sign     : stored sign
module alu_flags_reg
  import cpuy_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  flags_t d,
  output logic   cpu_carry,
  output logic   flag_zero,
  output logic   flag_sign
);

  flags_t flags_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= '0;
    end else if (load) begin
      flags_q <= d;
    end
  end

  assign cpu_carry = flags_q.carry;
  assign flag_zero = flags_q.zero;
  assign flag_sign = flags_q.sign;

endmodule

// File: rtl/alu_writeback.sv
// Result/flag writeback stage behind the ALU. Accepts one result per
// handshake and writes the low byte (and, for wide results, the high byte
// to dst+1) through a single stallable 8-bit register-file write port.
//   clk, rst    : clock, asynchronous active-low reset
//   alu         : result channel (slave side), see alu_writeback_if
//   rf_we       : register-file write request (high in WR_L/WR_H)
//   rf_waddr    : write address, holds last value when rf_we=0
//   rf_wdata    : write data, holds last value when rf_we=0
//   rf_busy     : write port denied this cycle, request is held
//   cpu_carry   : flag-register carry, wired back to the ALU
//   flag_zero   : flag-register zero
//   flag_sign   : flag-register sign
//   done        : registered pulse in the first IDLE cycle after the
//                 final byte of a result was written
//   state_dbg   : current FSM state
module alu_writeback
  import cpuy_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
)(
  input  logic                  clk,
  input  logic                  rst,
  alu_writeback_if.slave        alu,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [7:0]            rf_wdata,
  input  logic                  rf_busy,
  output logic                  cpu_carry,
  output logic                  flag_zero,
  output logic                  flag_sign,
  output logic                  done,
  output wb_state_t             state_dbg
);

  wb_state_t             state_q;
  wb_state_t             state_d;
  logic                  accept;
  logic                  go_high;
  logic                  done_d;

  logic [7:0]            result_h_q;
  logic [REG_ADDR_W-1:0] dst_q;
  logic                  wide_q;
  logic [REG_ADDR_W-1:0] dst_inc;

  localparam logic [REG_ADDR_W-1:0] ADDR_ONE = {{(REG_ADDR_W-1){1'b0}}, 1'b1};

  // Natural truncation gives the modulo-2^REG_ADDR_W wrap for the high byte.
  assign dst_inc = dst_q + ADDR_ONE;

  // Gate with rst so the producer never sees ready while reset is held.
  assign alu.in_ready = (state_q == IDLE) && rst;
  assign rf_we        = (state_q != IDLE);
  assign state_dbg    = state_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    go_high = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (alu.in_valid) begin
          accept  = 1'b1;
          state_d = WR_L;
        end
      end
      WR_L: begin
        if (!rf_busy) begin
          if (wide_q) begin
            go_high = 1'b1;
            state_d = WR_H;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WR_H: begin
        if (!rf_busy) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
    end
  end

  // rf_waddr/rf_wdata double as the low-byte latch: they are loaded on
  // accept and only change again when the FSM moves on to the high byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      result_h_q <= '0;
      dst_q      <= '0;
      wide_q     <= 1'b0;
    end else if (accept) begin
      rf_waddr   <= alu.dst;
      rf_wdata   <= alu.result_l;
      result_h_q <= alu.result_h;
      dst_q      <= alu.dst;
      wide_q     <= alu.wide;
    end else if (go_high) begin
      rf_waddr   <= dst_inc;
      rf_wdata   <= result_h_q;
    end
  end

  alu_flags_reg u_flags (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && alu.update_flags),
    .d         ('{carry: alu.carry, zero: alu.zero, sign: alu.sign}),
    .cpu_carry (cpu_carry),
    .flag_zero (flag_zero),
    .flag_sign (flag_sign)
  );

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;
  import cpuy_pkg::*;

  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [7:0]    rf_wdata;
  logic          rf_busy;
  logic          cpu_carry;
  logic          flag_zero;
  logic          flag_sign;
  logic          done;
  wb_state_t     state_dbg;

  int total = 0;
  int bad   = 0;

  alu_writeback_if #(.REG_ADDR_W(AW)) bus ();

  alu_writeback #(.REG_ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu       (bus.slave),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_busy   (rf_busy),
    .cpu_carry (cpu_carry),
    .flag_zero (flag_zero),
    .flag_sign (flag_sign),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] d,
                       input logic uf, input logic [7:0] rl, input logic [7:0] rh,
                       input logic c, input logic z, input logic s);
    bus.in_valid     = v;
    bus.wide         = w;
    bus.dst          = d;
    bus.update_flags = uf;
    bus.result_l     = rl;
    bus.result_h     = rh;
    bus.carry        = c;
    bus.zero         = z;
    bus.sign         = s;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // checks the write port in one call
  task automatic chk_wr(input string tag, input logic we, input logic [AW-1:0] a,
                        input logic [7:0] dat, input logic dn, input logic rdy);
    chk({tag, "_we"},    16'(rf_we),        16'(we));
    chk({tag, "_addr"},  16'(rf_waddr),     16'(a));
    chk({tag, "_data"},  16'(rf_wdata),     16'(dat));
    chk({tag, "_done"},  16'(done),         16'(dn));
    chk({tag, "_ready"}, 16'(bus.in_ready), 16'(rdy));
  endtask

  task automatic chk_flags(input string tag, input logic c, input logic z, input logic s);
    chk({tag, "_flags"}, 16'({cpu_carry, flag_zero, flag_sign}), 16'({c, z, s}));
  endtask

  initial begin
    rst     = 1'b0;
    rf_busy = 1'b0;
    drive(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    // reset state
    step();
    step();
    chk_wr("rst", 0, 0, 8'h00, 0, 0);
    chk_flags("rst", 0, 0, 0);
    chk("rst_state", 16'(state_dbg), 16'(IDLE));
    rst = 1'b1;
    #1;
    chk("rel_ready", 16'(bus.in_ready), 16'd1);
    step();

    // narrow ADD: dst=2, 0x3C, carry=1
    drive(1, 0, 3'd2, 1, 8'h3C, 8'h00, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    chk_wr("add_wl", 1, 3'd2, 8'h3C, 0, 0);
    chk_flags("add_wl", 1, 0, 0);
    step();
    chk_wr("add_done", 0, 3'd2, 8'h3C, 1, 1);
    chk_flags("add_done", 1, 0, 0);
    step();
    chk("add_done_clr", 16'(done), 16'd0);

    // wide MUL: dst=4, 0xE110
    drive(1, 1, 3'd4, 0, 8'h10, 8'hE1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    chk_wr("mul_wl", 1, 3'd4, 8'h10, 0, 0);
    step();
    chk_wr("mul_wh", 1, 3'd5, 8'hE1, 0, 0);
    chk("mul_state", 16'(state_dbg), 16'(WR_H));
    step();
    chk_wr("mul_done", 0, 3'd5, 8'hE1, 1, 1);
    chk_flags("mul_keep", 1, 0, 0);

    // stall 3 cycles on narrow dst=1, 0xAA; a second result waits on in_valid
    drive(1, 0, 3'd1, 0, 8'hAA, 8'h00, 0, 0, 0);
    rf_busy = 1'b1;
    step();
    drive(1, 0, 3'd6, 0, 8'h77, 8'h00, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      rf_busy = (i < 3);
      chk_wr($sformatf("stall%0d", i), 1, 3'd1, 8'hAA, 0, 0);
      step();
    end
    chk_wr("stall_done", 0, 3'd1, 8'hAA, 1, 1);
    step();
    drive(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    chk_wr("held_wl", 1, 3'd6, 8'h77, 0, 0);
    step();
    chk_wr("held_done", 0, 3'd6, 8'h77, 1, 1);
    step();
    chk("held_done_clr", 16'(done), 16'd0);

    // wrap: wide dst=7, high byte 0x55 lands at address 0; flags all set
    drive(1, 1, 3'd7, 1, 8'h01, 8'h55, 1, 1, 1);
    step();
    drive(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    chk_wr("wrap_wl", 1, 3'd7, 8'h01, 0, 0);
    chk_flags("wrap", 1, 1, 1);
    step();
    chk_wr("wrap_wh", 1, 3'd0, 8'h55, 0, 0);
    step();
    chk_wr("wrap_done", 0, 3'd0, 8'h55, 1, 1);

    // flags hold with update_flags=0, then reset in WR_H
    drive(1, 1, 3'd3, 0, 8'hAB, 8'hCD, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    chk_flags("hold", 1, 1, 1);
    step();
    chk_wr("rst_wh", 1, 3'd4, 8'hCD, 0, 0);
    rst = 1'b0;
    #1;
    chk("rstmid_we", 16'(rf_we), 16'd0);
    chk("rstmid_ready", 16'(bus.in_ready), 16'd0);
    chk("rstmid_state", 16'(state_dbg), 16'(IDLE));
    chk_flags("rstmid", 0, 0, 0);
    step();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_wr($sformatf("post%0d", i), 0, 3'd0, 8'h00, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
